// File: rtl/writeback_regfile_if.sv
// rtl/writeback_regfile_if.sv - W-stage write-back and D-stage read bundle for writeback_regfile
interface writeback_regfile_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             write_enable_RF_W;
    logic [1:0]       write_back_W;
    logic [XLEN-1:0]  alu_rsl_W;
    logic [XLEN-1:0]  write_back_data_W;
    logic [XLEN-1:0]  imm_extended_W;
    logic [XLEN-1:0]  pc4_W;
    logic [4:0]       rd_W;
    logic [4:0]       rs1_D;
    logic [4:0]       rs2_D;
    logic [XLEN-1:0]  rd1_D;
    logic [XLEN-1:0]  rd2_D;
    logic [XLEN-1:0]  result_W;
    logic             commit_W;
    logic [CNT_W-1:0] commit_cnt;

    modport master (
        output write_enable_RF_W, write_back_W, alu_rsl_W, write_back_data_W,
               imm_extended_W, pc4_W, rd_W, rs1_D, rs2_D,
        input  rd1_D, rd2_D, result_W, commit_W, commit_cnt
    );

    modport slave (
        input  write_enable_RF_W, write_back_W, alu_rsl_W, write_back_data_W,
               imm_extended_W, pc4_W, rd_W, rs1_D, rs2_D,
        output rd1_D, rd2_D, result_W, commit_W, commit_cnt
    );
endinterface

// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - W-stage result mux and 32x32 register file with W->D bypass
module writeback_regfile #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    writeback_regfile_if.slave wb
);
    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_IMM = 2'b10;
    localparam logic [1:0] SEL_PC4 = 2'b11;

    logic [XLEN-1:0]  regs_q [NREG];
    logic [CNT_W-1:0] commit_cnt_q;
    logic [CNT_W-1:0] commit_cnt_d;
    logic [XLEN-1:0]  result_d;
    logic             commit;
    logic [XLEN-1:0]  rd1;
    logic [XLEN-1:0]  rd2;

    always_comb begin
        result_d = wb.alu_rsl_W;
        unique case (wb.write_back_W)
            SEL_ALU: result_d = wb.alu_rsl_W;
            SEL_MEM: result_d = wb.write_back_data_W;
            SEL_IMM: result_d = wb.imm_extended_W;
            SEL_PC4: result_d = wb.pc4_W;
            default: result_d = wb.alu_rsl_W;
        endcase
    end

    // Reset gates commit so a write arriving with reset is dropped and never bypassed.
    assign commit = wb.write_enable_RF_W && (wb.rd_W != 5'd0) && !rst;

    always_comb begin
        commit_cnt_d = commit_cnt_q;
        if (commit) begin
            commit_cnt_d = commit_cnt_q + 1'b1;
        end
    end

    always_comb begin
        rd1 = '0;
        if (wb.rs1_D != 5'd0) begin
            if (commit && (wb.rd_W == wb.rs1_D)) begin
                rd1 = result_d;
            end else begin
                rd1 = regs_q[wb.rs1_D];
            end
        end
    end

    always_comb begin
        rd2 = '0;
        if (wb.rs2_D != 5'd0) begin
            if (commit && (wb.rd_W == wb.rs2_D)) begin
                rd2 = result_d;
            end else begin
                rd2 = regs_q[wb.rs2_D];
            end
        end
    end

    // Entry 0 is only ever cleared; commit excludes rd_W == 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            commit_cnt_q <= '0;
        end else begin
            if (commit) begin
                regs_q[wb.rd_W] <= result_d;
            end
            commit_cnt_q <= commit_cnt_d;
        end
    end

    assign wb.result_W   = result_d;
    assign wb.commit_W   = commit;
    assign wb.commit_cnt = commit_cnt_q;
    assign wb.rd1_D      = rd1;
    assign wb.rd2_D      = rd2;
endmodule
